// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM status encoding, arbiter states and the
// error completion word returned by the memory arbiter.
package cpu_types_pkg;

    // RAM status reported back to the arbiter.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter grant state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    // Load value returned on a watchdog or RAM error completion.
    localparam logic [31:0] BAD_WORD = 32'hBAD1_BAD1;

endpackage

// File: rtl/mem_arbiter.sv
// Memory arbiter: grants the single-ported RAM to the icache or dcache,
// returns wait/load handshakes, limits icache starvation and aborts
// accesses the RAM never completes.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              CLK,
    input  logic              nRST,
    // icache side
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    // dcache side
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    // RAM side
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    // status
    output logic              err
);

    localparam int              WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIM     = WD_W'(TIMEOUT);
    localparam logic [2:0]      STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [WORD_W-1:0] BAD_LOAD = WORD_W'(BAD_WORD);

    arb_state_t      state, next_state;
    ramstate_t       ram_st;
    logic [2:0]      starve_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            d_req;
    logic            i_done;
    logic            d_done;
    logic            wd_fail;

    assign ram_st = ramstate_t'(ramstate);
    assign d_req  = dREN | dWEN;

    // Grant state register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, regardless of block order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode and combinational RAM/cache handshake outputs.
    // NOTE: every output gets a default before the case statement, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        wd_fail    = 1'b0;

        case (state)
            IDLE: begin
                if (d_req && (starve_cnt < STARVE_LIM)) next_state = DGNT;
                else if (iREN)                          next_state = IGNT;
            end

            DGNT: begin
                if (!d_req) begin
                    // Requester withdrew: release the RAM without a pulse.
                    next_state = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramREN   = dREN;
                    ramWEN   = dWEN;
                    if (ram_st == ACCESS) begin
                        dwait      = 1'b0;
                        dload      = ramload;
                        d_done     = 1'b1;
                        next_state = IDLE;
                    end else if ((ram_st == ERROR) || (wd_cnt == WD_LIM)) begin
                        dwait      = 1'b0;
                        dload      = BAD_LOAD;
                        d_done     = 1'b1;
                        wd_fail    = 1'b1;
                        next_state = IDLE;
                    end
                end
            end

            IGNT: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (ram_st == ACCESS) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        i_done     = 1'b1;
                        next_state = IDLE;
                    end else if ((ram_st == ERROR) || (wd_cnt == WD_LIM)) begin
                        iwait      = 1'b0;
                        iload      = BAD_LOAD;
                        i_done     = 1'b1;
                        wd_fail    = 1'b1;
                        next_state = IDLE;
                    end
                end
            end

            default: next_state = IDLE;
        endcase
    end

    // Watchdog: counts granted cycles the RAM has not answered; held at
    // zero in IDLE so every grant starts from a clean count.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wd_cnt <= '0;
        end else if (state == IDLE) begin
            wd_cnt <= '0;
        end else if ((ram_st != ACCESS) && (wd_cnt != WD_LIM)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Starvation counter: data completions while the icache waits push it
    // up to the limit; an icache completion or an idle icache clears it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (i_done) begin
            starve_cnt <= '0;
        end else if (d_done && iREN) begin
            if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 3'd1;
        end else if ((state == IDLE) && !iREN) begin
            starve_cnt <= '0;
        end
    end

    // Sticky error flag, set by any watchdog or RAM error completion.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)        err <= 1'b0;
        else if (wd_fail) err <= 1'b1;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder for the cache request protocol. Accepts single-word requests from the instruction cache (read-only) and the data cache (read/write), arbitrates them onto the single-ported RAM, and returns each request's wait/load response. Sits between `icache`/`dcache` and the RAM model. Includes starvation control and an access watchdog.

## Interface
- `WORD_W`, 32: address and data width.
- `STARVE_MAX`, 4: number of consecutive data grants allowed while `iREN` is pending.
- `TIMEOUT`, 15: number of granted cycles without `ACCESS` before an error completion.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `iREN` in 1: icache read request.
- `iaddr` in WORD_W: icache address.
- `iwait` out 1: high = icache must hold; low for exactly one cycle = data valid.
- `iload` out WORD_W: icache read data.
- `dREN` / `dWEN` in 1: dcache read / write request (never both high).
- `daddr` / `dstore` in WORD_W: dcache address / write data.
- `dwait` out 1: dcache handshake, same rule as `iwait`.
- `dload` out WORD_W: dcache read data.
- `ramREN` / `ramWEN` out 1: RAM strobes.
- `ramaddr` / `ramstore` out WORD_W: RAM address / write data.
- `ramload` in WORD_W: RAM read data.
- `ramstate` in 2: RAM status. FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `err` out 1: sticky error flag, cleared only by reset.

## Operation
- **FSM states:** IDLE, IGNT, DGNT.
- **IDLE:** all RAM strobes are low and both waits are high.
  - With `dREN|dWEN` pending and `starve_cnt < STARVE_MAX`, go to DGNT.
  - Otherwise, with `iREN` pending, go to IGNT.
  - Otherwise stay in IDLE.
- **DGNT:** `ramaddr=daddr`, `ramstore=dstore`, `ramREN=dREN`, `ramWEN=dWEN`.
  - When `ramstate==ACCESS`: `dwait=0`, `dload=ramload`, next state IDLE.
- **IGNT:** `ramaddr=iaddr`, `ramREN=1`.
  - When `ramstate==ACCESS`: `iwait=0`, `iload=ramload`, next state IDLE.
- **Requester contract:** a requester holds its request, address and data stable until its wait drops.
- **Request dropped while granted:** strobes go low in that same cycle, the FSM returns to IDLE next cycle, and no wait pulse is issued.
- **Starvation counter** (`starve_cnt`, 3 bits):
  - Increments on each DGNT completion while `iREN` is high.
  - Clears on IGNT completion, or when `iREN` is low in IDLE.
  - Saturates at `STARVE_MAX`.
- **Watchdog counter:** counts granted cycles where `ramstate != ACCESS`; it is cleared on every grant entry.
  - Reaching `TIMEOUT`, or seeing `ramstate==ERROR`, forces completion: the granted wait goes low for one cycle, load=`32'hBAD1_BAD1`, `err` is set, and the FSM returns to IDLE.
- Load outputs are 0 whenever their wait is high.
- **Reset values:** state IDLE, `iwait=dwait=1`, `iload=dload=0`, `ramREN=ramWEN=0`, `ramaddr=ramstore=0`, `err=0`, all counters 0.
- **Reset mid-grant:** the transaction is abandoned and no wait pulse is issued.

## Timing
- Arbitration is registered: a request first seen in IDLE at cycle N gets its grant at N+1.
- Minimum latency (request at N, `ACCESS` at N+1): wait low at N+1, two cycles.
- Back-to-back requests incur one IDLE bubble between grants.
- RAM outputs and waits are combinational from state plus live inputs. No combinational path exists from `ramload` into the FSM.
- **Simultaneous i and d requests:** data is granted unless `starve_cnt==STARVE_MAX`, in which case instruction is granted.
- **Watchdog boundary:** error completion occurs in the cycle the counter equals `TIMEOUT`, i.e. the (TIMEOUT+1)th granted cycle.

## Structure
- Add `ramstate_t` (FREE/BUSY/ACCESS/ERROR) and `arb_state_t` to `cpu_types_pkg`.
- Add the error pattern `BAD_WORD` to `cpu_types_pkg`.
- The single RTL module has no sub-modules.
- The bench uses a separate behavioural `ram_model`, with configurable BUSY latency, as the RAM responder.

## Test plan
- `iREN=1`, `iaddr=0x40`, RAM 1-cycle latency returning `0x2002_0001` -> `iwait` low exactly one cycle at N+1, `iload=0x2002_0001`, `ramWEN` never high.
- `dWEN=1`, `daddr=0x100`, `dstore=0xCAFE_F00D`, 3-cycle BUSY -> `ramWEN` high 3 cycles then `ACCESS`, `dwait` low once, read-back of `0x100` returns `0xCAFE_F00D`.
- `iREN` and `dREN` held continuously -> grant sequence D,D,D,D,I,D,D,D,D,I; no icache starvation beyond 4 data grants.
- RAM stuck at BUSY with `dREN` held -> after 16 granted cycles `dwait` pulses low, `dload=0xBAD1_BAD1`, `err=1` stays high; next request completes normally.
- `dREN` dropped after 1 granted cycle -> `ramREN` low the same cycle, FSM in IDLE next cycle, no `dwait` pulse; a pending `iREN` is then granted.
- Assert `nRST` while in DGNT -> all outputs return to reset values asynchronously; after release, a new `iREN` completes with 2-cycle minimum latency.
